// File: rtl/sym_vn_lut_loader.sv
// Write-side loader for the dual-bank symmetric VN rank LUT: one full 128-entry refill per start.
// Optional checksum verification is built when SYM_VN_LOADER_CHECKSUM_EN is defined.
module sym_vn_lut_loader #(
   parameter int PAGE_W = 6,
   parameter int DATA_W = 4
) (
   input  logic                  write_clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            expected_sum,
   input  logic [2*DATA_W-1:0]   in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_W-1:0]     lut_in_bank0,
   output logic [DATA_W-1:0]     lut_in_bank1,
   output logic [PAGE_W-1:0]     page_write_addr,
   output logic                  write_addr_offset,
   output logic                  we,
   output logic                  busy,
   output logic                  done,
   output logic                  sum_err
);

   localparam int ADDR_W = PAGE_W + 1;
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                beat;
   logic                last_beat;
   logic                start_acc;

   logic [DATA_W-1:0]   bank0_q, bank1_q;
   logic [PAGE_W-1:0]   page_q;
   logic                offset_q;
   logic                we_q;

   assign in_ready  = (state_q == S_LOAD);
   assign busy      = (state_q == S_LOAD);
   assign done      = (state_q == S_DONE);
   assign beat      = in_valid && in_ready;
   assign last_beat = beat && (addr_q == ADDR_LAST);
   assign start_acc = (state_q == S_IDLE) && start;

   always_ff @(posedge write_clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               addr_d  = '0;
            end
         end
         S_LOAD: begin
            if (beat) begin
               addr_d = addr_q + 1'b1;
               if (addr_q == ADDR_LAST) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Write port is registered: a beat taken this cycle is written next cycle.
   always_ff @(posedge write_clk or posedge rst) begin
      if (rst) begin
         we_q     <= 1'b0;
         bank0_q  <= '0;
         bank1_q  <= '0;
         page_q   <= '0;
         offset_q <= 1'b0;
      end else begin
         we_q <= beat;
         if (beat) begin
            bank0_q  <= in_data[DATA_W-1:0];
            bank1_q  <= in_data[2*DATA_W-1:DATA_W];
            page_q   <= addr_q[PAGE_W-1:0];
            offset_q <= addr_q[PAGE_W];
         end
      end
   end

   assign we                = we_q;
   assign lut_in_bank0      = bank0_q;
   assign lut_in_bank1      = bank1_q;
   assign page_write_addr   = page_q;
   assign write_addr_offset = offset_q;

`ifdef SYM_VN_LOADER_CHECKSUM_EN
   function automatic logic [7:0] pair_sum(input logic [2*DATA_W-1:0] d);
      return 8'(d[DATA_W-1:0]) + 8'(d[2*DATA_W-1:DATA_W]);
   endfunction

   logic [7:0] acc_q;
   logic [7:0] exp_q;
   logic       sum_err_q;

   // The verdict includes the final beat so sum_err is already valid during DONE.
   always_ff @(posedge write_clk or posedge rst) begin
      if (rst) begin
         acc_q     <= '0;
         exp_q     <= '0;
         sum_err_q <= 1'b0;
      end else begin
         if (start_acc) begin
            acc_q <= '0;
            exp_q <= expected_sum;
         end else if (beat) begin
            acc_q <= acc_q + pair_sum(in_data);
         end
         if (last_beat) sum_err_q <= ((acc_q + pair_sum(in_data)) != exp_q);
      end
   end

   assign sum_err = sum_err_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{expected_sum, start_acc, last_beat};
   assign sum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Directed-sequence bench with randomized data for sym_vn_lut_loader, checked against a write-order model.
module tb_sym_vn_lut_loader;

   logic       write_clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] expected_sum;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] lut_in_bank0;
   logic [3:0] lut_in_bank1;
   logic [5:0] page_write_addr;
   logic       write_addr_offset;
   logic       we;
   logic       busy;
   logic       done;
   logic       sum_err;

   int   n_assert = 0;
   int   n_fail   = 0;
   logic exp_err_prev;

   always #5 write_clk = ~write_clk;

   sym_vn_lut_loader #(.PAGE_W(6), .DATA_W(4)) dut (
      .write_clk         (write_clk),
      .rst               (rst),
      .start             (start),
      .expected_sum      (expected_sum),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .lut_in_bank0      (lut_in_bank0),
      .lut_in_bank1      (lut_in_bank1),
      .page_write_addr   (page_write_addr),
      .write_addr_offset (write_addr_offset),
      .we                (we),
      .busy              (busy),
      .done              (done),
      .sum_err           (sum_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err(input logic [7:0] sum, input logic [7:0] exp);
`ifdef SYM_VN_LOADER_CHECKSUM_EN
      return sum != exp;
`else
      return 1'b0;
`endif
   endfunction

   // dmode: 0 random, 1 in_data = write index, 2 constant 0x11
   // gmode: 0 back-to-back, 1 drop every 3rd cycle, 2 random gaps
   task automatic do_load(input int dmode, input int gmode, input int restart_at,
                          input int abort_at, input logic [7:0] exp);
      logic [7:0] sum;
      logic [7:0] d;
      logic [7:0] last_d;
      int         sent;
      int         cyc;
      bit         v;
      sum = 8'h00; sent = 0; cyc = 0; last_d = 8'h00;
      start = 1'b1; expected_sum = exp; in_valid = 1'b0;
      @(posedge write_clk); #1;
      start = 1'b0;
      expected_sum = 8'($urandom);
      chk("busy_after_start", busy, 1);
      chk("ready_after_start", in_ready, 1);
      chk("we_after_start", we, 0);
      chk("sum_err_hold", sum_err, exp_err_prev);
      while (sent < 128 && cyc < 2000) begin
         case (gmode)
            0:       v = 1'b1;
            1:       v = (cyc % 3) != 2;
            default: v = ($urandom_range(3) != 0);
         endcase
         case (dmode)
            0:       d = 8'($urandom);
            1:       d = 8'(sent);
            default: d = 8'h11;
         endcase
         in_valid = v; in_data = d; start = (sent == restart_at);
         @(posedge write_clk); #1;
         cyc++;
         chk("we", we, v);
         if (v) begin
            chk("page", page_write_addr, sent % 64);
            chk("offset", write_addr_offset, sent / 64);
            chk("bank0", lut_in_bank0, d[3:0]);
            chk("bank1", lut_in_bank1, d[7:4]);
            sum = sum + d[3:0] + d[7:4];
            last_d = d;
            sent++;
         end else if (sent > 0) begin
            chk("page_hold", page_write_addr, (sent - 1) % 64);
            chk("offset_hold", write_addr_offset, (sent - 1) / 64);
            chk("data_hold", {lut_in_bank1, lut_in_bank0}, last_d);
         end
         chk("done", done, sent == 128);
         chk("busy", busy, sent < 128);
         chk("in_ready", in_ready, sent < 128);
         if (sent == 128) chk("sum_err_done", sum_err, model_err(sum, exp));
         if (sent == abort_at && sent < 128) begin
            rst = 1'b1; in_valid = 1'b0; start = 1'b0;
            #1;
            chk("abort_we", we, 0);
            chk("abort_busy", busy, 0);
            chk("abort_ready", in_ready, 0);
            chk("abort_page", page_write_addr, 0);
            chk("abort_sum_err", sum_err, 0);
            @(posedge write_clk); #1;
            chk("abort_we_in_rst", we, 0);
            rst = 1'b0;
            exp_err_prev = 1'b0;
            @(posedge write_clk); #1;
            return;
         end
      end
      if (sent < 128) chk("load_timeout", sent, 128);
      in_valid = 1'b0; start = 1'b0;
      @(posedge write_clk); #1;
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_we", we, 0);
      chk("idle_ready", in_ready, 0);
      exp_err_prev = model_err(sum, exp);
      chk("sum_err_after", sum_err, exp_err_prev);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; expected_sum = 8'h00;
      exp_err_prev = 1'b0;
      #2;
      chk("rst_we", we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_sum_err", sum_err, 0);
      chk("rst_data", {lut_in_bank1, lut_in_bank0}, 0);
      chk("rst_addr", {write_addr_offset, page_write_addr}, 0);
      @(posedge write_clk); #1;
      rst = 1'b0;
      @(posedge write_clk); #1;
      chk("idle_ignores_nothing", busy, 0);

      do_load(1, 0, -1, -1, 8'($urandom));
      do_load(0, 1, 40, -1, 8'($urandom));
      do_load(0, 0, -1, 70, 8'h00);
      do_load(1, 0, -1, -1, 8'h40);
      do_load(2, 0, -1, -1, 8'h00);
      do_load(2, 1, -1, -1, 8'h01);
      do_load(0, 2, 40, -1, 8'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
